// File: rtl/ram_write_addr_gen.sv
// ----------------------------------------------------------------------------
// ram_write_addr_gen
//
// Receive-side write sequencer for three channel RAMs. After a frame sync
// pulse it accepts one 10-bit word per dRS strobe and de-interleaves the
// words round-robin into three channel RAMs. Each RAM word holds three
// 10-bit lanes. The line order is ch1 L0, ch2 L0, ch3 L0, ch1 L1, ...,
// ch3 L2. For every accepted word the block presents data, lane select,
// channel address and a one-clock write enable one clock later.
//
// Parameters
//   WORDS_PER_FRAME : words accepted per sync (multiple of 3, 3..765)
//   TIMEOUT         : idle clocks between strobes before abort (1..255)
//
// Optional feature macro
//   PARITY_CHK_EN   : when defined, din[9] is checked as odd parity over
//                     din[8:0]. A bad word suppresses its write enable and
//                     pulses oErr. The frame carries on.
//
// Ports
//   clk         in   system clock, rising edge
//   rst         in   asynchronous reset, active-high
//   sync        in   frame-start pulse
//   dRS         in   word-received strobe
//   din[9:0]    in   received word, valid with dRS
//   dout[9:0]   out  RAM write data
//   addr1..3    out  write address per channel (7 bit)
//   wrEn1..3    out  write enable per channel, 1-clk pulse
//   mux3[1:0]   out  lane select of current write
//   pack[1:0]   out  channel of next expected word
//   oFrameDone  out  1-clk pulse, frame completed
//   oErr        out  1-clk pulse, frame aborted or parity error
// ----------------------------------------------------------------------------
module ram_write_addr_gen #(
   parameter int WORDS_PER_FRAME = 9,
   parameter int TIMEOUT         = 255
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       sync,
   input  logic       dRS,
   input  logic [9:0] din,
   output logic [9:0] dout,
   output logic [6:0] addr1,
   output logic [6:0] addr2,
   output logic [6:0] addr3,
   output logic       wrEn1,
   output logic       wrEn2,
   output logic       wrEn3,
   output logic [1:0] mux3,
   output logic [1:0] pack,
   output logic       oFrameDone,
   output logic       oErr
);

   localparam logic [9:0] WCNT_LAST = 10'(WORDS_PER_FRAME - 1);
   localparam logic [7:0] TMO_LAST  = 8'(TIMEOUT - 1);

   typedef enum logic {
      ST_IDLE,
      ST_RUN
   } state_t;

   state_t     state_reg, state_next;

   // Position of the next word inside the frame.
   logic [1:0] pack_reg,  pack_next;
   logic [1:0] lane_reg,  lane_next;
   logic [9:0] wcnt_reg,  wcnt_next;
   logic [7:0] tmo_reg,   tmo_next;

   // Per-channel write address, plus its snapshot at frame start. The
   // snapshot is restored when a frame is aborted.
   logic [6:0] wra_reg       [3];
   logic [6:0] wra_next      [3];
   logic [6:0] wra_start_reg [3];
   logic [6:0] wra_start_next[3];

   // Registered outputs.
   logic [9:0] dout_reg,  dout_next;
   logic [1:0] mux3_reg,  mux3_next;
   logic [6:0] addr_reg  [3];
   logic [6:0] addr_next [3];
   logic [2:0] wren_reg,  wren_next;
   logic       done_reg,  done_next;
   logic       err_reg,   err_next;

   logic       parity_ok;

`ifdef PARITY_CHK_EN
   // Odd parity: the ten bits together must have an odd number of ones.
   assign parity_ok = ^din;
`else
   assign parity_ok = 1'b1;
`endif

   // ------------------------------------------------------------------------
   // Next-state and output logic
   // ------------------------------------------------------------------------
   always_comb begin
      state_next     = state_reg;
      pack_next      = pack_reg;
      lane_next      = lane_reg;
      wcnt_next      = wcnt_reg;
      tmo_next       = tmo_reg;
      wra_next       = wra_reg;
      wra_start_next = wra_start_reg;
      dout_next      = dout_reg;
      mux3_next      = mux3_reg;
      addr_next      = addr_reg;
      wren_next      = 3'b000;
      done_next      = 1'b0;
      err_next       = 1'b0;

      case (state_reg)
         ST_IDLE: begin
            // A strobe arriving together with sync is dropped. The frame
            // starts with the next clock.
            if (sync) begin
               state_next     = ST_RUN;
               pack_next      = 2'd0;
               lane_next      = 2'd0;
               wcnt_next      = '0;
               tmo_next       = '0;
               wra_start_next = wra_reg;
            end
         end

         ST_RUN: begin
            if (sync) begin
               // Early sync: discard the partial frame and restart in
               // place. The snapshot stays valid because wrA is rolled
               // back to it.
               err_next  = 1'b1;
               wra_next  = wra_start_reg;
               pack_next = 2'd0;
               lane_next = 2'd0;
               wcnt_next = '0;
               tmo_next  = '0;
            end else if (dRS) begin
               // A strobe takes priority over a timeout in the same clock.
               tmo_next  = '0;
               dout_next = din;
               mux3_next = lane_reg;
               for (int i = 0; i < 3; i++) begin
                  if (pack_reg == 2'(i)) begin
                     addr_next[i] = wra_reg[i];
                     wren_next[i] = parity_ok;
                  end
               end
               if (!parity_ok) begin
                  err_next = 1'b1;
               end

               // Round-robin: channel, then lane, then RAM address.
               if (pack_reg == 2'd2) begin
                  pack_next = 2'd0;
                  if (lane_reg == 2'd2) begin
                     lane_next = 2'd0;
                     for (int i = 0; i < 3; i++) begin
                        wra_next[i] = wra_reg[i] + 7'd1;
                     end
                  end else begin
                     lane_next = lane_reg + 2'd1;
                  end
               end else begin
                  pack_next = pack_reg + 2'd1;
               end

               if (wcnt_reg == WCNT_LAST) begin
                  done_next  = 1'b1;
                  wcnt_next  = '0;
                  state_next = ST_IDLE;
               end else begin
                  wcnt_next = wcnt_reg + 10'd1;
               end
            end else if (tmo_reg == TMO_LAST) begin
               // Idle too long inside a frame. Writes already issued stay
               // in RAM; only the address counters are rolled back.
               err_next   = 1'b1;
               wra_next   = wra_start_reg;
               tmo_next   = '0;
               state_next = ST_IDLE;
            end else begin
               tmo_next = tmo_reg + 8'd1;
            end
         end

         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // State registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= ST_IDLE;
         pack_reg  <= '0;
         lane_reg  <= '0;
         wcnt_reg  <= '0;
         tmo_reg   <= '0;
         dout_reg  <= '0;
         mux3_reg  <= '0;
         wren_reg  <= '0;
         done_reg  <= 1'b0;
         err_reg   <= 1'b0;
         for (int i = 0; i < 3; i++) begin
            wra_reg[i]       <= '0;
            wra_start_reg[i] <= '0;
            addr_reg[i]      <= '0;
         end
      end else begin
         state_reg <= state_next;
         pack_reg  <= pack_next;
         lane_reg  <= lane_next;
         wcnt_reg  <= wcnt_next;
         tmo_reg   <= tmo_next;
         dout_reg  <= dout_next;
         mux3_reg  <= mux3_next;
         wren_reg  <= wren_next;
         done_reg  <= done_next;
         err_reg   <= err_next;
         for (int i = 0; i < 3; i++) begin
            wra_reg[i]       <= wra_next[i];
            wra_start_reg[i] <= wra_start_next[i];
            addr_reg[i]      <= addr_next[i];
         end
      end
   end

   // ------------------------------------------------------------------------
   // Output mapping
   // ------------------------------------------------------------------------
   assign dout       = dout_reg;
   assign addr1      = addr_reg[0];
   assign addr2      = addr_reg[1];
   assign addr3      = addr_reg[2];
   assign wrEn1      = wren_reg[0];
   assign wrEn2      = wren_reg[1];
   assign wrEn3      = wren_reg[2];
   assign mux3       = mux3_reg;
   assign pack       = pack_reg;
   assign oFrameDone = done_reg;
   assign oErr       = err_reg;

endmodule

// File: tb/tb_ram_write_addr_gen.sv
// ----------------------------------------------------------------------------
// Testbench for ram_write_addr_gen. Expected write/error/done events are
// queued when a strobe is driven and checked against DUT outputs one clock
// later. The first frame uses a literal table; later frames derive channel,
// lane and address from the word's position in the frame.
// ----------------------------------------------------------------------------
module tb_ram_write_addr_gen;

   localparam int WPF = 9;
   localparam int TMO = 20;

   logic       clk  = 1'b0;
   logic       rst  = 1'b1;
   logic       sync = 1'b0;
   logic       dRS  = 1'b0;
   logic [9:0] din  = '0;
   logic [9:0] dout;
   logic [6:0] addr1, addr2, addr3;
   logic       wrEn1, wrEn2, wrEn3;
   logic [1:0] mux3, pack;
   logic       oFrameDone, oErr;

   ram_write_addr_gen #(
      .WORDS_PER_FRAME(WPF),
      .TIMEOUT        (TMO)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .sync      (sync),
      .dRS       (dRS),
      .din       (din),
      .dout      (dout),
      .addr1     (addr1),
      .addr2     (addr2),
      .addr3     (addr3),
      .wrEn1     (wrEn1),
      .wrEn2     (wrEn2),
      .wrEn3     (wrEn3),
      .mux3      (mux3),
      .pack      (pack),
      .oFrameDone(oFrameDone),
      .oErr      (oErr)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int         cyc;
      logic [2:0] wren;
      logic [6:0] addr;
      logic [1:0] mux3;
      logic [9:0] dout;
      logic       done;
      logic       err;
   } ev_t;

   typedef struct {
      logic [9:0] din;
      logic [2:0] wren;
      logic [1:0] lane;
      logic [6:0] addr;
      logic       done;
   } vec_t;

   ev_t        q[$];
   int         n_vec = 0;
   int         n_err = 0;
   logic [6:0] exp_base = '0;

   function automatic logic [9:0] odd_word(input logic [8:0] x);
      return {~(^x), x};
   endfunction

   function automatic logic [6:0] addr_of(input logic [2:0] w);
      case (w)
         3'b001:  return addr1;
         3'b010:  return addr2;
         3'b100:  return addr3;
         default: return 7'h7f;
      endcase
   endfunction

   // ------------------------------------------------------------------------
   // Event monitor / scoreboard
   // ------------------------------------------------------------------------
   ev_t  mon_e;
   logic mon_ok;

   always @(negedge clk) begin
      if (!rst) begin
         while (q.size() > 0 && q[0].cyc < cyc) begin
            n_vec++;
            n_err++;
            $display("FAIL missing_event: required at cycle %0d wren=%b err=%b done=%b, nothing seen by cycle %0d",
                     q[0].cyc, q[0].wren, q[0].err, q[0].done, cyc);
            void'(q.pop_front());
         end
         if ({wrEn3, wrEn2, wrEn1} != 3'b000 || oErr || oFrameDone) begin
            n_vec++;
            if (q.size() == 0 || q[0].cyc != cyc) begin
               n_err++;
               $display("FAIL unexpected_event: cycle %0d wren=%b err=%b done=%b, none required",
                        cyc, {wrEn3, wrEn2, wrEn1}, oErr, oFrameDone);
            end else begin
               mon_e  = q.pop_front();
               mon_ok = ({wrEn3, wrEn2, wrEn1} == mon_e.wren) &&
                        (oErr == mon_e.err) && (oFrameDone == mon_e.done);
               if (mon_e.wren != 3'b000) begin
                  mon_ok = mon_ok && (dout == mon_e.dout) && (mux3 == mon_e.mux3) &&
                           (addr_of(mon_e.wren) == mon_e.addr);
               end
               if (!mon_ok) begin
                  n_err++;
                  $display("FAIL write_event: cycle %0d got wren=%b addr=%0d mux3=%0d dout=%h err=%b done=%b, required wren=%b addr=%0d mux3=%0d dout=%h err=%b done=%b",
                           cyc, {wrEn3, wrEn2, wrEn1}, addr_of(mon_e.wren), mux3, dout, oErr, oFrameDone,
                           mon_e.wren, mon_e.addr, mon_e.mux3, mon_e.dout, mon_e.err, mon_e.done);
               end else begin
                  $display("event ok: cycle %0d wren=%b addr=%0d mux3=%0d dout=%h err=%b done=%b",
                           cyc, mon_e.wren, mon_e.addr, mon_e.mux3, mon_e.dout, mon_e.err, mon_e.done);
               end
            end
         end
      end
   end

   // ------------------------------------------------------------------------
   // Stimulus helpers
   // ------------------------------------------------------------------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_vec++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %0d, required %0d", name, act, req);
      end else begin
         $display("check ok: %s = %0d", name, act);
      end
   endtask

   task automatic put_word(input logic [9:0] d, input ev_t e, input bit push);
      dRS = 1'b1;
      din = d;
      if (push) begin
         e.cyc = cyc + 1;
         q.push_back(e);
      end
      @(negedge clk);
      dRS = 1'b0;
   endtask

   task automatic pulse_sync(input bit with_drs);
      sync = 1'b1;
      dRS  = with_drs;
      din  = 10'h2aa;
      @(negedge clk);
      sync = 1'b0;
      dRS  = 1'b0;
   endtask

   task automatic expect_err(input int at_cyc);
      ev_t e;
      e.cyc  = at_cyc;
      e.wren = 3'b000;
      e.addr = '0;
      e.mux3 = '0;
      e.dout = '0;
      e.done = 1'b0;
      e.err  = 1'b1;
      q.push_back(e);
   endtask

   // Word k of a 9-word frame: channel k%3, lane k/3, current base address.
   task automatic frame_word(input int k, input logic [9:0] d);
      ev_t e;
      e.cyc  = 0;
      e.wren = 3'b001 << (k % 3);
      e.addr = exp_base;
      e.mux3 = 2'((k / 3) % 3);
      e.dout = d;
      e.done = (k == WPF - 1);
      e.err  = 1'b0;
      put_word(d, e, 1'b1);
      if (k == WPF - 1) exp_base = exp_base + 7'd1;
   endtask

   task automatic full_frame();
      pulse_sync(1'b0);
      for (int k = 0; k < WPF; k++) frame_word(k, odd_word(9'($urandom)));
   endtask

   // ------------------------------------------------------------------------
   // Test sequence
   // ------------------------------------------------------------------------
   vec_t vec[WPF];
   ev_t  ev;

   initial begin
      vec[0] = '{10'd1, 3'b001, 2'd0, 7'd0, 1'b0};
      vec[1] = '{10'd2, 3'b010, 2'd0, 7'd0, 1'b0};
      vec[2] = '{10'd3, 3'b100, 2'd0, 7'd0, 1'b0};
      vec[3] = '{10'd4, 3'b001, 2'd1, 7'd0, 1'b0};
      vec[4] = '{10'd5, 3'b010, 2'd1, 7'd0, 1'b0};
      vec[5] = '{10'd6, 3'b100, 2'd1, 7'd0, 1'b0};
      vec[6] = '{10'd7, 3'b001, 2'd2, 7'd0, 1'b0};
      vec[7] = '{10'd8, 3'b010, 2'd2, 7'd0, 1'b0};
      vec[8] = '{10'd9, 3'b100, 2'd2, 7'd0, 1'b1};
`ifdef PARITY_CHK_EN
      for (int i = 0; i < WPF; i++) vec[i].din = odd_word(vec[i].din[8:0]);
`endif

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_wren",  {29'd0, wrEn3, wrEn2, wrEn1}, 0);
      check("rst_addr",  {11'd0, addr3, addr2, addr1}, 0);
      check("rst_dout",  {22'd0, dout}, 0);
      check("rst_flags", {26'd0, mux3, pack, oErr, oFrameDone}, 0);
      rst = 1'b0;
      @(negedge clk);

      // Test 1: first frame from the literal table
      pulse_sync(1'b0);
      for (int i = 0; i < WPF; i++) begin
         ev.cyc  = 0;
         ev.wren = vec[i].wren;
         ev.addr = vec[i].addr;
         ev.mux3 = vec[i].lane;
         ev.dout = vec[i].din;
         ev.done = vec[i].done;
         ev.err  = 1'b0;
         put_word(vec[i].din, ev, 1'b1);
      end
      exp_base = 7'd1;
      check("t1_pack_end", {30'd0, pack}, 0);
      // Strobe in IDLE must be ignored; outputs hold their last values.
      put_word(10'h155, ev, 1'b0);
      @(negedge clk);
      check("t1_hold_dout", {22'd0, dout}, {22'd0, vec[8].din});
      check("t1_hold_mux3", {30'd0, mux3}, 2);

      // Test 2: address walk 1..127, then wrap to 0
      for (int f = 0; f < 127; f++) full_frame();
      check("t2_addr3_max", {25'd0, addr3}, 127);
      full_frame();
      check("t2_addr1_wrap", {25'd0, addr1}, 0);

      // Test 3: timeout after four words, then rollback
      pulse_sync(1'b0);
      for (int k = 0; k < 4; k++) frame_word(k, odd_word(9'($urandom)));
      check("t3_pack_mid", {30'd0, pack}, 1);
      expect_err(cyc + TMO);
      repeat (TMO + 2) @(negedge clk);
      put_word(10'h0ff, ev, 1'b0);
      full_frame();
      // Strobe on the expiry clock wins over the timeout.
      pulse_sync(1'b0);
      repeat (TMO - 1) @(negedge clk);
      for (int k = 0; k < WPF; k++) frame_word(k, odd_word(9'($urandom)));

      // Test 4: sync + dRS in RUN after five words
      pulse_sync(1'b0);
      for (int k = 0; k < 5; k++) frame_word(k, odd_word(9'($urandom)));
      expect_err(cyc + 1);
      pulse_sync(1'b1);
      for (int k = 0; k < WPF; k++) frame_word(k, odd_word(9'($urandom)));

      // Test 5: async reset between writes 6 and 7
      pulse_sync(1'b0);
      for (int k = 0; k < 6; k++) frame_word(k, odd_word(9'($urandom)));
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("t5_rst_wren", {29'd0, wrEn3, wrEn2, wrEn1}, 0);
      check("t5_rst_addr", {11'd0, addr3, addr2, addr1}, 0);
      check("t5_rst_dout", {22'd0, dout}, 0);
      check("t5_rst_misc", {26'd0, mux3, pack, oErr, oFrameDone}, 0);
      @(negedge clk);
      rst      = 1'b0;
      exp_base = '0;
      put_word(10'h3c3, ev, 1'b0);
      // sync with dRS in IDLE: the word is dropped, frame starts next clock.
      pulse_sync(1'b1);
      for (int k = 0; k < WPF; k++) frame_word(k, odd_word(9'($urandom)));

`ifdef PARITY_CHK_EN
      // Test 6: bad parity on word 2 (index 1)
      pulse_sync(1'b0);
      frame_word(0, odd_word(9'h011));
      ev.cyc  = 0;
      ev.wren = 3'b000;
      ev.addr = '0;
      ev.mux3 = '0;
      ev.dout = '0;
      ev.done = 1'b0;
      ev.err  = 1'b1;
      put_word(odd_word(9'h022) ^ 10'h200, ev, 1'b1);
      for (int k = 2; k < WPF; k++) frame_word(k, odd_word(9'($urandom)));
`endif

      repeat (5) @(negedge clk);
      n_vec++;
      if (q.size() != 0) begin
         n_err++;
         $display("FAIL queue_drain: %0d events outstanding, required 0", q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
